// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared types and byte-merge helper for the multi-port register file.
package regfile_mp_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] uint32_t;
    typedef logic [3:0]  byte_en_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    function automatic uint32_t merge_bytes(uint32_t old_val, uint32_t new_val, byte_en_t be);
        uint32_t res;
        res = old_val;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write-back, issue and flush signals between decode and the register file.
interface regfile_mp_if #(
    parameter int NR = 4,
    parameter int NW = 2
);
    import regfile_mp_pkg::*;

    reg_addr_t [NR-1:0] raddr;
    uint32_t   [NR-1:0] rdata;
    logic      [NR-1:0] rbusy;
    byte_en_t  [NW-1:0] we;
    reg_addr_t [NW-1:0] waddr;
    uint32_t   [NW-1:0] wdata;
    logic      [NW-1:0] wb_retire;
    logic               iss_valid;
    reg_addr_t          iss_addr;
    logic               iss_ready;
    logic               flush;

    modport master (
        output raddr, we, waddr, wdata, wb_retire, iss_valid, iss_addr, flush,
        input  rdata, rbusy, iss_ready
    );

    modport slave (
        input  raddr, we, waddr, wdata, wb_retire, iss_valid, iss_addr, flush,
        output rdata, rbusy, iss_ready
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: per-register pending-producer counters with issue back-pressure and busy lookup.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NR    = 4,
    parameter int NW    = 2,
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  reg_addr_t [NR-1:0] raddr,
    output logic      [NR-1:0] rbusy,
    input  reg_addr_t [NW-1:0] waddr,
    input  logic      [NW-1:0] wb_retire,
    input  logic               iss_valid,
    input  reg_addr_t          iss_addr,
    output logic               iss_ready,
    input  logic               flush
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [CNT_W-1:0] pend_q [32];
    logic [CNT_W-1:0] pend_d [32];
    logic             iss_ok;
    int               cnt;

    assign iss_ready = !flush && (iss_addr == REG_ZERO || pend_q[iss_addr] != PEND_MAX);
    assign iss_ok    = iss_valid && iss_ready;

    // Retires beyond the outstanding count clamp at zero rather than wrapping.
    always_comb begin
        cnt       = 0;
        pend_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            cnt = int'(pend_q[r]) + ((iss_ok && iss_addr == reg_addr_t'(r)) ? 1 : 0);
            for (int i = 0; i < NW; i++)
                cnt = cnt - ((wb_retire[i] && waddr[i] == reg_addr_t'(r)) ? 1 : 0);
            pend_d[r] = (flush || cnt < 0) ? '0 : CNT_W'(cnt);
        end
    end

    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NR; i++)
            rbusy[i] = pend_q[raddr[i]] != '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            for (int r = 0; r < 32; r++) pend_q[r] <= '0;
        else
            pend_q <= pend_d;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NR-read / NW-write MIPS register file with byte enables and pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int NR    = 4,
    parameter int NW    = 2,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    regfile_mp_if.slave  bus
);

    uint32_t mem_q  [1:31];
    uint32_t mem_d  [1:31];
    uint32_t rd_src [1:31];

    // Later ports overwrite earlier ones per byte, giving the highest index priority.
    always_comb begin
        mem_d = mem_q;
        for (int r = 1; r < 32; r++)
            for (int i = 0; i < NW; i++)
                mem_d[r] = merge_bytes(mem_d[r], bus.wdata[i],
                                       bus.waddr[i] == reg_addr_t'(r) ? bus.we[i] : '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            for (int r = 1; r < 32; r++) mem_q[r] <= '0;
        else
            mem_q <= mem_d;
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_src = mem_d;
`else
    assign rd_src = mem_q;
`endif

    always_comb begin
        bus.rdata = '0;
        for (int i = 0; i < NR; i++)
            bus.rdata[i] = (bus.raddr[i] == REG_ZERO) ? '0 : rd_src[bus.raddr[i]];
    end

    regfile_scoreboard #(
        .NR    (NR),
        .NW    (NW),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk       (clk),
        .resetn    (resetn),
        .raddr     (bus.raddr),
        .rbusy     (bus.rbusy),
        .waddr     (bus.waddr),
        .wb_retire (bus.wb_retire),
        .iss_valid (bus.iss_valid),
        .iss_addr  (bus.iss_addr),
        .iss_ready (bus.iss_ready),
        .flush     (bus.flush)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed tests for regfile_mp (4 read ports, 2 write ports, CNT_W=2).
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    regfile_mp_if #(.NR(4), .NW(2)) bus ();

    regfile_mp #(.NR(4), .NW(2), .CNT_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.raddr     = '0;
        bus.we        = '0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.wb_retire = '0;
        bus.iss_valid = 1'b0;
        bus.iss_addr  = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #23;
        resetn = 1'b1;
        tick();
        for (int a = 0; a < 32; a++) begin
            for (int p = 0; p < 4; p++) bus.raddr[p] = reg_addr_t'(a);
            bus.iss_addr = reg_addr_t'(a);
            #1;
            for (int p = 0; p < 4; p++) begin
                total++;
                if (bus.rdata[p] !== 32'h0 || bus.rbusy[p] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_read a=%0d p=%0d got data=%h busy=%b exp data=0 busy=0",
                             a, p, bus.rdata[p], bus.rbusy[p]);
                end
            end
            total++;
            if (bus.iss_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready a=%0d got=%b exp=1", a, bus.iss_ready);
            end
        end
        idle_inputs();
    endtask

    task automatic test_byte_write();
        bus.we[0] = 4'b1111; bus.waddr[0] = 5'd5; bus.wdata[0] = 32'h11223344;
        tick();
        bus.we[0] = 4'b0101; bus.wdata[0] = 32'hAABBCCDD;
        tick();
        idle_inputs();
        bus.raddr[2] = 5'd5;
        #1;
        total++;
        if (bus.rdata[2] !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL byte_merge got=%h exp=11bb33dd", bus.rdata[2]);
        end
    endtask

    task automatic test_priority();
        bus.we[0] = 4'b1111; bus.waddr[0] = 5'd7; bus.wdata[0] = 32'h00000001;
        bus.we[1] = 4'b1111; bus.waddr[1] = 5'd7; bus.wdata[1] = 32'hFFFFFFFF;
        tick();
        bus.waddr[0] = 5'd8; bus.wdata[0] = 32'h12345678;
        bus.we[1] = 4'b0011; bus.waddr[1] = 5'd8; bus.wdata[1] = 32'hAAAAAAAA;
        tick();
        bus.we = {4'b1111, 4'b1111}; bus.waddr = '0; bus.wdata = {32'hDEAD0001, 32'hDEAD0002};
        tick();
        idle_inputs();
        bus.raddr[0] = 5'd7; bus.raddr[1] = 5'd8; bus.raddr[3] = 5'd0;
        #1;
        total++;
        if (bus.rdata[0] !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL port_priority got=%h exp=ffffffff", bus.rdata[0]);
        end
        total++;
        if (bus.rdata[1] !== 32'h1234AAAA) begin
            bad++;
            $display("FAIL byte_priority got=%h exp=1234aaaa", bus.rdata[1]);
        end
        total++;
        if (bus.rdata[3] !== 32'h0) begin
            bad++;
            $display("FAIL r0_write got=%h exp=0", bus.rdata[3]);
        end
    endtask

    task automatic test_saturation();
        bus.raddr[0] = 5'd9;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (bus.iss_ready !== 1'b1) begin
                bad++;
                $display("FAIL issue_ready k=%0d got=%b exp=1", k, bus.iss_ready);
            end
            tick();
        end
        total++;
        if (bus.iss_ready !== 1'b0 || bus.rbusy[0] !== 1'b1) begin
            bad++;
            $display("FAIL saturated got ready=%b busy=%b exp ready=0 busy=1", bus.iss_ready, bus.rbusy[0]);
        end
        tick();
        bus.iss_valid = 1'b0;
        bus.waddr[0] = 5'd9; bus.wb_retire[0] = 1'b1;
        tick();
        bus.iss_valid = 1'b1;
        #1;
        total++;
        if (bus.iss_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_retire got=%b exp=1", bus.iss_ready);
        end
        tick();
        bus.wb_retire[0] = 1'b0;
        tick();
        total++;
        if (bus.iss_ready !== 1'b0) begin
            bad++;
            $display("FAIL issue_retire_same_cycle got ready=%b exp=0", bus.iss_ready);
        end
        bus.iss_valid = 1'b0;
        bus.waddr[1] = 5'd9; bus.wb_retire = 2'b11;
        tick();
        total++;
        if (bus.rbusy[0] !== 1'b1) begin
            bad++;
            $display("FAIL dual_retire got busy=%b exp=1", bus.rbusy[0]);
        end
        bus.wb_retire = 2'b10;
        tick();
        total++;
        if (bus.rbusy[0] !== 1'b0) begin
            bad++;
            $display("FAIL last_retire got busy=%b exp=0", bus.rbusy[0]);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        bus.raddr[0] = 5'd3; bus.raddr[1] = 5'd4; bus.raddr[2] = 5'd6;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
        tick();
        bus.iss_addr = 5'd4;
        tick();
        total++;
        if (bus.rbusy[1:0] !== 2'b11) begin
            bad++;
            $display("FAIL busy_before_flush got=%b exp=11", bus.rbusy[1:0]);
        end
        bus.iss_addr = 5'd6; bus.flush = 1'b1;
        bus.we[0] = 4'b1111; bus.waddr[0] = 5'd10; bus.wdata[0] = 32'hCAFEF00D;
        #1;
        total++;
        if (bus.iss_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_during_flush got=%b exp=0", bus.iss_ready);
        end
        tick();
        idle_inputs();
        bus.raddr[0] = 5'd3; bus.raddr[1] = 5'd4; bus.raddr[2] = 5'd6; bus.raddr[3] = 5'd10;
        #1;
        total++;
        if (bus.rbusy !== 4'b0000) begin
            bad++;
            $display("FAIL busy_after_flush got=%b exp=0000", bus.rbusy);
        end
        total++;
        if (bus.rdata[3] !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL write_during_flush got=%h exp=cafef00d", bus.rdata[3]);
        end
        bus.waddr[0] = 5'd3; bus.wb_retire[0] = 1'b1;
        tick();
        bus.wb_retire[0] = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
        tick();
        bus.iss_valid = 1'b0;
        total++;
        if (bus.rbusy[0] !== 1'b1) begin
            bad++;
            $display("FAIL issue_after_underflow got busy=%b exp=1", bus.rbusy[0]);
        end
        bus.wb_retire[0] = 1'b1;
        tick();
        idle_inputs();
        bus.raddr[0] = 5'd3;
        #1;
        total++;
        if (bus.rbusy[0] !== 1'b0) begin
            bad++;
            $display("FAIL underflow_saturate got busy=%b exp=0", bus.rbusy[0]);
        end
    endtask

    task automatic test_bypass();
        uint32_t exp_now;
        bus.we[0] = 4'b1111; bus.waddr[0] = 5'd12; bus.wdata[0] = 32'h01020304;
        tick();
        bus.raddr[0] = 5'd12; bus.wdata[0] = 32'hDEADBEEF;
`ifdef REGFILE_BYPASS_EN
        exp_now = 32'hDEADBEEF;
`else
        exp_now = 32'h01020304;
`endif
        #1;
        total++;
        if (bus.rdata[0] !== exp_now) begin
            bad++;
            $display("FAIL same_cycle_read got=%h exp=%h", bus.rdata[0], exp_now);
        end
        tick();
        idle_inputs();
        bus.raddr[0] = 5'd12;
        #1;
        total++;
        if (bus.rdata[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL next_cycle_read got=%h exp=deadbeef", bus.rdata[0]);
        end
    endtask

    task automatic test_async_reset();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd20;
        tick();
        idle_inputs();
        bus.raddr[0] = 5'd20; bus.raddr[1] = 5'd12;
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (bus.rbusy[0] !== 1'b0 || bus.rdata[1] !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got busy=%b data=%h exp busy=0 data=0", bus.rbusy[0], bus.rdata[1]);
        end
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_priority();
        test_saturation();
        test_flush();
        test_bypass();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
